// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a req/ack fetch to instruction memory,
// buffers the returned word for IF/ID and applies ID redirects with delay-slot semantics.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  localparam int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            im_req,
  output logic [XLEN-1:0] im_addr,
  input  logic            im_ack,
  input  logic [XLEN-1:0] im_rdata,
  output logic [XLEN-1:0] Instr_IF,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] PC4_IF,
  output logic            valid_IF,
  output logic            adel_IF
);

  localparam logic [XLEN-1:0] WORD_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] pc, pc_nx;
  logic [XLEN-1:0] buf_word, buf_word_nx;
  logic            pend_v, pend_v_nx;
  logic [XLEN-1:0] pend_pc, pend_pc_nx;
  logic [XLEN-1:0] target_c;
  logic            take_target_c;

  // Next-pc priority on a hand-off: live redirect, then latched redirect, then sequential.
  always_comb begin
    target_c = pc + WORD_STEP;
    if (redirect) begin
      target_c = redirect_pc;
    end else if (pend_v) begin
      target_c = pend_pc;
    end
  end

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    buf_word_nx   = buf_word;
    pend_v_nx     = pend_v;
    pend_pc_nx    = pend_pc;
    take_target_c = 1'b0;

    unique case (state)
      FETCH: begin
        // im_req gates the ack so nothing is accepted in the first cycle after reset.
        if (im_ack && im_req) begin
          buf_word_nx = im_rdata;
          state_nx    = READY;
        end
        if (redirect) begin
          pend_v_nx  = 1'b1;
          pend_pc_nx = redirect_pc;
        end
      end
      READY, ERR: begin
        if (stall) begin
          if (redirect) begin
            pend_v_nx  = 1'b1;
            pend_pc_nx = redirect_pc;
          end
        end else begin
          // An error marker with no new target stays parked at its pc.
          take_target_c = (state == READY) || redirect || pend_v;
        end
      end
      default: begin
        state_nx = FETCH;
      end
    endcase

    if (take_target_c) begin
      pc_nx     = target_c;
      pend_v_nx = 1'b0;
      state_nx  = (target_c[1:0] != 2'b00) ? ERR : FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      buf_word <= '0;
      pend_v   <= 1'b0;
      pend_pc  <= '0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      buf_word <= buf_word_nx;
      pend_v   <= pend_v_nx;
      pend_pc  <= pend_pc_nx;
    end
  end

  // Outputs registered from next-state so ack->valid and hand-off->req are one cycle each.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_req   <= 1'b0;
      im_addr  <= {RESET_PC[XLEN-1:2], 2'b00};
      Instr_IF <= '0;
      PC_IF    <= RESET_PC;
      PC4_IF   <= RESET_PC + WORD_STEP;
      valid_IF <= 1'b0;
      adel_IF  <= 1'b0;
    end else begin
      im_req   <= (state_nx == FETCH);
      im_addr  <= {pc_nx[XLEN-1:2], 2'b00};
      Instr_IF <= (state_nx == READY) ? buf_word_nx : '0;
      PC_IF    <= pc_nx;
      PC4_IF   <= pc_nx + WORD_STEP;
      valid_IF <= (state_nx != FETCH);
      adel_IF  <= (state_nx == ERR);
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- The instruction-fetch stage of the P6 pipeline, directly upstream of the IF/ID register.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Buffers the returned word and presents Instr_IF/PC_IF/PC4_IF to IF/ID.
- Inserts nop bubbles while a fetch is outstanding and applies branch/jump redirects from ID with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, PC loaded on reset; first fetch address.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  from hazard unit; 1 = IF/ID is not loading this cycle (same signal that drives IF/ID en low).
- redirect  in  1  ID stage resolved a taken branch/jump this cycle.
- redirect_pc  in  32  target address for redirect.
- im_req  out  1  instruction-memory request.
- im_addr  out  32  request address; word aligned.
- im_ack  in  1  one-cycle pulse; im_rdata valid this cycle.
- im_rdata  in  32  instruction word.
- Instr_IF  out  32  instruction to IF/ID; 0 (nop) when valid_IF=0 or adel_IF=1.
- PC_IF  out  32  address of Instr_IF.
- PC4_IF  out  32  PC_IF+4, modulo 2^32.
- valid_IF  out  1  Instr_IF holds a real fetched word (or an error marker).
- adel_IF  out  1  misaligned fetch address; Instr_IF forced 0.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC; state=FETCH; pend_v=0; buf=0.
  - Outputs: im_req=0, Instr_IF=0, PC_IF=RESET_PC, PC4_IF=RESET_PC+4, valid_IF=0, adel_IF=0.
  - im_req stays 0 while reset=0; it is asserted from the first clk edge after release.
  - Reset mid-request abandons the request; the bench must not deliver a stale im_ack after reset.
- State registers: pc[31:0], buf[31:0], pend_v, pend_pc[31:0], state ∈ {FETCH, READY, ERR}.
- PC_IF=pc and PC4_IF=pc+4 in every state.
- FETCH:
  - im_req=1, im_addr=pc; both held stable until im_ack. Memory may ack in the same cycle as the request or any later cycle.
  - valid_IF=0, Instr_IF=0.
  - On im_ack: buf<=im_rdata, go to READY. stall is ignored in FETCH.
- READY:
  - im_req=0, valid_IF=1, Instr_IF=buf.
  - stall=1: hold all state.
  - stall=0: this is the hand-off (IF/ID captures this cycle). Next pc is selected by priority:
    - redirect=1 → redirect_pc;
    - else pend_v=1 → pend_pc;
    - else pc+4.
  - On hand-off, clear pend_v. Go to ERR if nextpc[1:0]≠0, else to FETCH.
- ERR:
  - im_req=0, valid_IF=1, adel_IF=1, Instr_IF=0, PC_IF=misaligned pc.
  - On hand-off (stall=0): a redirect or pending target is applied exactly as in READY. With neither, remain in ERR at the same pc.
- Redirect / delay slot:
  - A redirect that is not consumed by a hand-off (state FETCH, or READY/ERR with stall=1) is latched: pend_v<=1, pend_pc<=redirect_pc.
  - The instruction currently in flight or buffered (branch_pc+4) is the delay slot and is always delivered; the word after it comes from the target.
  - A second redirect while pend_v=1 overwrites pend_pc (last wins).
- Throughput:
  - ack→valid_IF is 1 cycle; hand-off→im_req is 1 cycle.
  - With zero-wait memory, one instruction is delivered every 2 cycles.
- Arithmetic: all PC adds are 32-bit with wrap; 32'hFFFF_FFFC+4=0.

Test Plan:
1. Release reset, memory acks in the same cycle, stall=0 → im_addr sequence 0x3000, 0x3004, 0x3008; valid_IF high every 2nd cycle; PC4_IF=0x3004 when PC_IF=0x3000.
2. Memory acks 3 cycles after req at 0x3000 → valid_IF=0 and Instr_IF=0 for those cycles; im_addr stable at 0x3000; valid_IF=1 the cycle after ack.
3. READY with stall=1 for 4 cycles → Instr_IF/PC_IF frozen, im_req=0; first cycle with stall=0 hands off and next im_addr=PC_IF+4.
4. redirect=1, redirect_pc=0x3100 pulsed while in FETCH at 0x3008 → 0x3008 is still delivered (delay slot), next im_addr=0x3100, pend_v cleared; repeat with the redirect coinciding with a hand-off → next im_addr=0x3100 directly.
5. redirect_pc=0x3102 → after the delay slot, adel_IF=1, Instr_IF=0, PC_IF=0x3102, no im_req; a later redirect to 0x3200 on hand-off → FETCH at 0x3200.
6. Assert reset while FETCH is waiting for ack → outputs return to reset values immediately (asynchronously); after release, first im_addr=0x3000.
